// File: rtl/div_recon_pkg.sv
// Shared types and sizing for the shift-add divider reconstruction unit.
package div_recon_pkg;

   localparam int unsigned WDefault = 8;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   // Guarded so a degenerate W=1 still gets a 1-bit counter.
   function automatic int unsigned cnt_width(input int unsigned w);
      return (w > 1) ? $clog2(w) : 1;
   endfunction

   localparam int unsigned CntW = cnt_width(WDefault);

endpackage

// File: rtl/div_recon_step.sv
// One shift-add iteration: conditionally add the shifted divisor into the accumulator.
module div_recon_step
   import div_recon_pkg::*;
#(
   parameter int unsigned W = WDefault
) (
   input  logic [2*W-1:0] acc,
   input  logic [2*W-1:0] md,
   input  logic           mq_bit,
   output logic [2*W-1:0] acc_next
);

   assign acc_next = mq_bit ? acc + md : acc;

endmodule

// File: rtl/div_recon_mult.sv
// Rebuilds the dividend p = q*y + r from a divider result, one quotient bit per cycle.
// Optional DIV_RECON_ERR_EN adds x_ref comparison outputs err and mismatch.
module div_recon_mult
   import div_recon_pkg::*;
#(
   parameter int unsigned W = WDefault
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [W-1:0]   q,
   input  logic [W-1:0]   y,
   input  logic [W-1:0]   r,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [2*W-1:0] p
`ifdef DIV_RECON_ERR_EN
   ,
   input  logic [2*W-1:0] x_ref,
   output logic [2*W-1:0] err,
   output logic           mismatch
`endif
);

   localparam int unsigned CW = cnt_width(W);

   state_t         state_q, state_d;
   logic [2*W-1:0] acc_q, acc_d, md_q, md_d, p_q, p_d, acc_step;
   logic [W-1:0]   mq_q, mq_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic           last;

   div_recon_step #(.W(W)) u_step (
      .acc      (acc_q),
      .md       (md_q),
      .mq_bit   (mq_q[0]),
      .acc_next (acc_step)
   );

   assign last = (cnt_q == CW'(W - 1));

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      md_d    = md_q;
      mq_d    = mq_q;
      cnt_d   = cnt_q;
      p_d     = p_q;
      unique case (state_q)
         IDLE: begin
            if (in_valid) begin
               acc_d   = {{W{1'b0}}, r};
               mq_d    = q;
               md_d    = {{W{1'b0}}, y};
               cnt_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            acc_d = acc_step;
            md_d  = md_q << 1;
            mq_d  = mq_q >> 1;
            cnt_d = cnt_q + CW'(1);
            // Result register only updates here, so aborted runs never leak partial sums.
            if (last) begin
               p_d     = acc_step;
               state_d = DONE;
            end
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         acc_q   <= '0;
         md_q    <= '0;
         mq_q    <= '0;
         cnt_q   <= '0;
         p_q     <= '0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         md_q    <= md_d;
         mq_q    <= mq_d;
         cnt_q   <= cnt_d;
         p_q     <= p_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign p         = p_q;

`ifdef DIV_RECON_ERR_EN
   logic [2*W-1:0] x_ref_q, err_q;
   logic           mismatch_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         x_ref_q    <= '0;
         err_q      <= '0;
         mismatch_q <= 1'b0;
      end else begin
         if (state_q == IDLE && in_valid) x_ref_q <= x_ref;
         if (state_q == RUN && last) begin
            err_q      <= (acc_step >= x_ref_q) ? acc_step - x_ref_q : x_ref_q - acc_step;
            mismatch_q <= (acc_step != x_ref_q);
         end
      end
   end

   assign err      = err_q;
   assign mismatch = mismatch_q;
`endif

endmodule

// File: tb/tb_div_recon_mult.sv
// Directed and randomized bench for div_recon_mult against an arithmetic reference.
module tb_div_recon_mult;

   logic        clk = 1'b0;
   logic        rst, in_valid, out_ready, in_ready, out_valid;
   logic [7:0]  q, y, r;
   logic [15:0] p, x_ref;
`ifdef DIV_RECON_ERR_EN
   logic [15:0] err;
   logic        mismatch;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   div_recon_mult #(.W(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .q         (q),
      .y         (y),
      .r         (r),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .p         (p)
`ifdef DIV_RECON_ERR_EN
      ,
      .x_ref     (x_ref),
      .err       (err),
      .mismatch  (mismatch)
`endif
   );

   function automatic logic [15:0] recon(input logic [7:0] a, input logic [7:0] b,
                                          input logic [7:0] c);
      return 16'(a) * 16'(b) + 16'(c);
   endfunction

   function automatic logic [15:0] absdiff(input logic [15:0] a, input logic [15:0] b);
      return (a >= b) ? a - b : b - a;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Full transaction with out_ready high: accept at T, result at T+9, idle at T+10.
   task automatic do_op(input logic [7:0] qa, input logic [7:0] ya, input logic [7:0] ra,
                        input logic [15:0] xr, input string tag);
      logic [15:0] exp;
      int n;
      exp = recon(qa, ya, ra);
      n = 0;
      out_ready = 1'b1;
      while (!in_ready && n < 40) begin
         tick();
         n++;
      end
      chk({tag, "_ready"}, 64'(in_ready), 64'(1));
      q = qa; y = ya; r = ra; x_ref = xr; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      q = 8'($urandom); y = 8'($urandom); r = 8'($urandom); x_ref = 16'($urandom);
      chk({tag, "_busy"}, 64'(in_ready), 64'(0));
      repeat (7) tick();
      chk({tag, "_early"}, 64'(out_valid), 64'(0));
      tick();
      chk({tag, "_valid"}, 64'(out_valid), 64'(1));
      chk({tag, "_p"}, 64'(p), 64'(exp));
`ifdef DIV_RECON_ERR_EN
      chk({tag, "_err"}, 64'(err), 64'(absdiff(exp, xr)));
      chk({tag, "_mismatch"}, 64'(mismatch), 64'(exp != xr));
`endif
      tick();
      chk({tag, "_idle"}, 64'(in_ready), 64'(1));
      chk({tag, "_novalid"}, 64'(out_valid), 64'(0));
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      logic [7:0]  qa, ya, ra;
      logic [15:0] pa, pb, xr;

      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      q = '0; y = '0; r = '0; x_ref = '0;
      repeat (2) tick();
      chk("rst_in_ready", 64'(in_ready), 64'(1));
      chk("rst_out_valid", 64'(out_valid), 64'(0));
      chk("rst_p", 64'(p), 64'(0));
`ifdef DIV_RECON_ERR_EN
      chk("rst_err", 64'(err), 64'(0));
      chk("rst_mismatch", 64'(mismatch), 64'(0));
`endif
      rst = 1'b0;
      out_ready = 1'b1;
      tick();
      chk("idle_out_ready_noeffect", 64'(out_valid), 64'(0));

      do_op(8'h0C, 8'h0A, 8'h05, 16'h0080, "tp_basic");
      chk("tp_basic_const", 64'(p), 64'h007D);
      do_op(8'h0C, 8'h0A, 8'h05, 16'h007D, "tp_exact");
      do_op(8'hFF, 8'hFF, 8'hFF, 16'hFF00, "tp_max");
      chk("tp_max_const", 64'(p), 64'hFF00);
      do_op(8'h00, 8'h37, 8'h12, 16'h0012, "tp_q0");
      do_op(8'h01, 8'h00, 8'h09, 16'h0000, "tp_y0");

      for (int i = 0; i < 24; i++) begin
         qa = 8'($urandom); ya = 8'($urandom); ra = 8'($urandom);
         xr = (i % 3 == 0) ? recon(qa, ya, ra) : 16'($urandom);
         do_op(qa, ya, ra, xr, "rand");
      end

      // Backpressure: result held, new requests ignored until after handoff.
      pa = recon(8'h21, 8'h13, 8'h40);
      pb = recon(8'h44, 8'h11, 8'h02);
      out_ready = 1'b0;
      q = 8'h21; y = 8'h13; r = 8'h40; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      repeat (8) tick();
      chk("bp_valid", 64'(out_valid), 64'(1));
      chk("bp_p", 64'(p), 64'(pa));
      for (int i = 0; i < 5; i++) begin
         in_valid = (i % 2 == 0);
         q = 8'($urandom); y = 8'($urandom); r = 8'($urandom);
         tick();
         chk("bp_hold_p", 64'(p), 64'(pa));
         chk("bp_hold_ready", 64'(in_ready), 64'(0));
         chk("bp_hold_valid", 64'(out_valid), 64'(1));
      end
      q = 8'h44; y = 8'h11; r = 8'h02; in_valid = 1'b1; out_ready = 1'b1;
      tick();
      chk("bp_after_ready", 64'(in_ready), 64'(1));
      chk("bp_after_valid", 64'(out_valid), 64'(0));
      tick();
      chk("bp_accepted", 64'(in_ready), 64'(0));
      in_valid = 1'b0;
      repeat (7) tick();
      chk("bp2_early", 64'(out_valid), 64'(0));
      tick();
      chk("bp2_valid", 64'(out_valid), 64'(1));
      chk("bp2_p", 64'(p), 64'(pb));
      tick();

      // Reset during the 4th RUN cycle aborts the operation.
      q = 8'h5A; y = 8'h33; r = 8'h07; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      repeat (3) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("abort_valid", 64'(out_valid), 64'(0));
      chk("abort_ready", 64'(in_ready), 64'(1));
      chk("abort_p", 64'(p), 64'(0));
      do_op(8'h03, 8'h05, 8'h01, 16'h0010, "post_rst");
      chk("post_rst_const", 64'(p), 64'h0010);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
